// File: rtl/ctrl_pkg.sv
// Shared definitions for the iteration controller: state encoding and
// default counter sizing.
package ctrl_pkg;

  localparam int unsigned ITER_W_DEF   = 8;
  localparam int unsigned MAX_ITER_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_IN = 3'd1,
    ST_INIT    = 3'd2,
    ST_MUL     = 3'd3,
    ST_RES     = 3'd4,
    ST_ACT     = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

endpackage

// File: rtl/iter_counter.sv
// Pass counter for the iteration controller: clear at run start, count
// completed passes, and flag when the next increment reaches the limit.
module iter_counter
  import ctrl_pkg::*;
#(
  parameter int unsigned ITER_W   = ITER_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ITER_W-1:0] cnt,
  output logic              last
);

  localparam logic [ITER_W-1:0] LAST_CNT = ITER_W'(MAX_ITER - 1);

  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  // The current pass is the last one allowed when its increment hits MAX_ITER.
  assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/iter_controller.sv
// Sequencer for an iterative datapath: LOAD_IN, INIT, then repeated
// MUL/RES/ACT passes until convergence or the iteration limit.
module iter_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned ITER_W   = ITER_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              done_in,
  output logic              ld_in,
  output logic              ld_init,
  output logic              ld_mul,
  output logic              ld_res,
  output logic              ld_act,
  output logic              busy,
  output logic              finished,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt
);

  state_e state_q;
  state_e state_d;
  logic   timeout_q;
  logic   timeout_d;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_last;

  iter_counter #(
    .ITER_W  (ITER_W),
    .MAX_ITER(MAX_ITER)
  ) u_iter_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (iter_cnt),
    .last(cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_LOAD_IN;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      ST_LOAD_IN: state_d = ST_INIT;
      ST_INIT:    state_d = ST_MUL;
      ST_MUL:     state_d = ST_RES;
      ST_RES:     state_d = ST_ACT;
      ST_ACT: begin
        cnt_inc = 1'b1;
        if (done_in) begin
          state_d = ST_DONE;
        end else if (cnt_last) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort cancels every pending update so counter and timeout keep their values.
    if (abort) begin
      state_d   = ST_IDLE;
      timeout_d = timeout_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    ld_in    = 1'b0;
    ld_init  = 1'b0;
    ld_mul   = 1'b0;
    ld_res   = 1'b0;
    ld_act   = 1'b0;
    busy     = 1'b0;
    finished = 1'b0;
    case (state_q)
      ST_LOAD_IN: begin ld_in   = 1'b1; busy = 1'b1; end
      ST_INIT:    begin ld_init = 1'b1; busy = 1'b1; end
      ST_MUL:     begin ld_mul  = 1'b1; busy = 1'b1; end
      ST_RES:     begin ld_res  = 1'b1; busy = 1'b1; end
      ST_ACT:     begin ld_act  = 1'b1; busy = 1'b1; end
      ST_DONE:    finished = 1'b1;
      default:    ;
    endcase
  end

  assign timeout = timeout_q;

endmodule
